prog_fetch: RTL and testbench

//   Instruction-fetch sequencer for the PROG program ROM (synchronous read, 1-cycle latency).

---
 rtl/prog_fetch.sv | 112 +++++++++++
 tb/tb_prog_fetch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_fetch.sv
// Instruction-fetch sequencer for the PROG ROM: owns the PC, reads 1- or 2-byte
// instructions through a 1-cycle synchronous ROM and presents them on a valid/ready port.
module prog_fetch #(
    parameter int unsigned    AW       = 8,
    parameter int unsigned    DW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          halt,
    input  logic          jump_req,
    input  logic [AW-1:0] jump_addr,
    output logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic          ins_valid,
    input  logic          ins_ready,
    output logic [DW-1:0] ins_opcode,
    output logic [DW-1:0] ins_operand,
    output logic          ins_two,
    output logic [AW-1:0] ins_pc,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP_REQ,
        S_OP_CAP,
        S_ARG_CAP,
        S_HOLD
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] pc_step;
    logic          op_is_two;

    assign pc_plus1  = pc + AW'(1);
    assign pc_step   = ins_two ? AW'(2) : AW'(1);
    assign op_is_two = prog_data[DW-1];

    // While the opcode is being captured, the operand read is already issued at pc+1
    // (wraps to 0 at the top of the ROM); every other state addresses the opcode.
    assign prog_addr = (state == S_OP_CAP) ? pc_plus1 : pc;

    // Fetch FSM; priority: halt > jump > handshake > sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            ins_valid   <= 1'b0;
            ins_opcode  <= '0;
            ins_operand <= '0;
            ins_two     <= 1'b0;
            ins_pc      <= '0;
            halted      <= 1'b1;
        end else if (halt) begin
            state     <= S_IDLE;
            ins_valid <= 1'b0;
            halted    <= 1'b1;
        end else if (jump_req && (state != S_IDLE)) begin
            // Discards any partial or held instruction; a same-cycle handshake still counts.
            state     <= S_OP_REQ;
            pc        <= jump_addr;
            ins_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_OP_REQ;
                        pc     <= RESET_PC;
                        halted <= 1'b0;
                    end
                end
                S_OP_REQ: begin
                    state <= S_OP_CAP;
                end
                S_OP_CAP: begin
                    ins_opcode <= prog_data;
                    ins_pc     <= pc;
                    ins_two    <= op_is_two;
                    if (op_is_two) begin
                        state <= S_ARG_CAP;
                    end else begin
                        ins_operand <= '0;
                        ins_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_ARG_CAP: begin
                    ins_operand <= prog_data;
                    ins_valid   <= 1'b1;
                    state       <= S_HOLD;
                end
                S_HOLD: begin
                    if (ins_ready) begin
                        pc        <= pc + pc_step;
                        ins_valid <= 1'b0;
                        state     <= S_OP_REQ;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    ins_valid <= 1'b0;
                    halted    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_fetch.sv
// Directed bench for prog_fetch: table-driven instruction stream plus hand-written
// stall, jump, halt, reset and PC-wrap sequences against a behavioural 1-cycle ROM.
module tb_prog_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt, jump_req, ins_ready;
    logic [7:0] jump_addr, prog_addr, prog_data, ins_opcode, ins_operand, ins_pc;
    logic       ins_valid, ins_two, halted;

    logic       start1, halt1, jump_req1, ins_ready1;
    logic [7:0] jump_addr1, prog_addr1, prog_data1, ins_opcode1, ins_operand1, ins_pc1;
    logic       ins_valid1, ins_two1, halted1;

    logic [7:0] rom [256];

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        prog_data  <= rom[prog_addr];
        prog_data1 <= rom[prog_addr1];
    end

    prog_fetch #(.AW(8), .DW(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
        .jump_req(jump_req), .jump_addr(jump_addr), .prog_addr(prog_addr),
        .prog_data(prog_data), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_opcode(ins_opcode), .ins_operand(ins_operand), .ins_two(ins_two),
        .ins_pc(ins_pc), .halted(halted)
    );

    prog_fetch #(.AW(8), .DW(8), .RESET_PC(8'hFF)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start1), .halt(halt1),
        .jump_req(jump_req1), .jump_addr(jump_addr1), .prog_addr(prog_addr1),
        .prog_data(prog_data1), .ins_valid(ins_valid1), .ins_ready(ins_ready1),
        .ins_opcode(ins_opcode1), .ins_operand(ins_operand1), .ins_two(ins_two1),
        .ins_pc(ins_pc1), .halted(halted1)
    );

    typedef struct {
        logic [7:0] opcode;
        logic [7:0] operand;
        logic       two;
        logic [7:0] pc;
        int         lat;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts clock edges until ins_valid rises; gives up after 20.
    task automatic wait_valid(output int n);
        n = 0;
        while (!ins_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_valid1(output int n);
        n = 0;
        while (!ins_valid1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;

        vecs[0] = '{8'h01, 8'h00, 1'b0, 8'h00, 2};
        vecs[1] = '{8'h02, 8'h00, 1'b0, 8'h01, 2};
        vecs[2] = '{8'h80, 8'h2A, 1'b1, 8'h02, 3};
        vecs[3] = '{8'h03, 8'h00, 1'b0, 8'h04, 2};
        vecs[4] = '{8'hC5, 8'h7E, 1'b1, 8'h05, 3};
        vecs[5] = '{8'h7F, 8'h00, 1'b0, 8'h07, 2};
        vecs[6] = '{8'hFF, 8'h10, 1'b1, 8'h08, 3};

        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0]  = 8'h01; rom[1]  = 8'h02; rom[2]  = 8'h80; rom[3]  = 8'h2A;
        rom[4]  = 8'h03; rom[5]  = 8'hC5; rom[6]  = 8'h7E; rom[7]  = 8'h7F;
        rom[8]  = 8'hFF; rom[9]  = 8'h10; rom[10] = 8'h91; rom[11] = 8'h33;
        rom[12] = 8'hA0; rom[13] = 8'h11; rom[8'h40] = 8'h05; rom[8'h50] = 8'h07;

        start = 0; halt = 0; jump_req = 0; jump_addr = 0; ins_ready = 0;
        start1 = 0; halt1 = 0; jump_req1 = 0; jump_addr1 = 0; ins_ready1 = 0;
        rst_n = 0;
        #12;
        check("rst_halted", 32'(halted), 32'h1);
        check("rst_valid", 32'(ins_valid), 32'h0);
        check("rst_addr", 32'(prog_addr), 32'h00);
        check("rst_addr_wrapdut", 32'(prog_addr1), 32'hFF);
        rst_n = 1;
        tick();

        // Sequential stream with ready held high
        ins_ready = 1;
        start = 1;
        tick();
        start = 0;
        check("start_halted", 32'(halted), 32'h0);
        for (int i = 0; i < 7; i++) begin
            wait_valid(n);
            check($sformatf("v%0d_lat", i), 32'(n), 32'(vecs[i].lat));
            check($sformatf("v%0d_opcode", i), 32'(ins_opcode), 32'(vecs[i].opcode));
            check($sformatf("v%0d_operand", i), 32'(ins_operand), 32'(vecs[i].operand));
            check($sformatf("v%0d_two", i), 32'(ins_two), 32'(vecs[i].two));
            check($sformatf("v%0d_pc", i), 32'(ins_pc), 32'(vecs[i].pc));
            tick();
            if (i == 6) ins_ready = 0;
        end
        check("after_stream_addr", 32'(prog_addr), 32'h0A);

        // Stall in HOLD for 5 cycles
        wait_valid(n);
        check("stall_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(ins_valid), 32'h1);
            check("stall_opcode", 32'(ins_opcode), 32'h91);
            check("stall_operand", 32'(ins_operand), 32'h33);
            check("stall_addr", 32'(prog_addr), 32'h0A);
        end
        ins_ready = 1;
        tick();
        check("stall_release_valid", 32'(ins_valid), 32'h0);
        check("stall_release_addr", 32'(prog_addr), 32'h0C);

        // Jump while the operand of A0 is being captured
        tick();
        tick();
        jump_req = 1; jump_addr = 8'h40;
        tick();
        jump_req = 0;
        check("jump_valid", 32'(ins_valid), 32'h0);
        check("jump_addr", 32'(prog_addr), 32'h40);
        wait_valid(n);
        check("jump_lat", 32'(n), 32'd2);
        check("jump_pc", 32'(ins_pc), 32'h40);
        check("jump_opcode", 32'(ins_opcode), 32'h05);

        // Jump coinciding with handshake in HOLD
        jump_req = 1; jump_addr = 8'h50;
        tick();
        jump_req = 0;
        check("jhs_valid", 32'(ins_valid), 32'h0);
        check("jhs_addr", 32'(prog_addr), 32'h50);
        wait_valid(n);
        check("jhs_pc", 32'(ins_pc), 32'h50);
        check("jhs_opcode", 32'(ins_opcode), 32'h07);

        // Halt in HOLD, then ignored jump in IDLE, then restart
        halt = 1; ins_ready = 0;
        tick();
        halt = 0;
        check("halt_halted", 32'(halted), 32'h1);
        check("halt_valid", 32'(ins_valid), 32'h0);
        check("halt_addr", 32'(prog_addr), 32'h50);
        jump_req = 1; jump_addr = 8'h20;
        tick();
        jump_req = 0;
        check("idle_jump_halted", 32'(halted), 32'h1);
        check("idle_jump_addr", 32'(prog_addr), 32'h50);
        start = 1;
        tick();
        start = 0;
        check("restart_addr", 32'(prog_addr), 32'h00);
        wait_valid(n);
        check("restart_lat", 32'(n), 32'd2);
        check("restart_opcode", 32'(ins_opcode), 32'h01);

        // Async reset during OP_CAP
        ins_ready = 1;
        tick();
        tick();
        check("pre_rst_addr", 32'(prog_addr), 32'h02);
        #2 rst_n = 0;
        #1;
        check("arst_valid", 32'(ins_valid), 32'h0);
        check("arst_halted", 32'(halted), 32'h1);
        check("arst_addr", 32'(prog_addr), 32'h00);
        check("arst_opcode", 32'(ins_opcode), 32'h00);
        #3 rst_n = 1;
        tick();

        // Wrap: opcode at 0xFF takes operand from 0x00
        rom[8'hFF] = 8'h81; rom[0] = 8'h55; rom[1] = 8'h06;
        ins_ready1 = 1;
        start1 = 1;
        tick();
        start1 = 0;
        wait_valid1(n);
        check("wrap_lat", 32'(n), 32'd3);
        check("wrap_opcode", 32'(ins_opcode1), 32'h81);
        check("wrap_operand", 32'(ins_operand1), 32'h55);
        check("wrap_two", 32'(ins_two1), 32'h1);
        check("wrap_pc", 32'(ins_pc1), 32'hFF);
        tick();
        wait_valid1(n);
        check("wrap_next_pc", 32'(ins_pc1), 32'h01);
        check("wrap_next_opcode", 32'(ins_opcode1), 32'h06);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
